// File: rtl/vend_pkg.sv
// Shared types, coin encodings and helpers for the vending-machine transaction sequencer.
// Credit and prices are counted in 5rs units.
package vend_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    localparam logic [1:0] UNIT_5  = 2'd1;
    localparam logic [1:0] UNIT_10 = 2'd2;

    // Widest packed price vector price_at() can slice (N_ITEMS * CREDIT_W must fit).
    localparam int PRICE_VEC_MAX = 256;

    // Value of a coin code in units; invalid codes are worth nothing.
    function automatic logic [1:0] coin_units(input logic [1:0] code);
        logic [1:0] units;
        case (code)
            COIN_5:  units = UNIT_5;
            COIN_10: units = UNIT_10;
            default: units = 2'd0;
        endcase
        return units;
    endfunction

    // Price of item idx from a packed vector of width-bit fields, item i at [i*width +: width].
    function automatic logic [31:0] price_at(input logic [PRICE_VEC_MAX-1:0] vec,
                                             input int unsigned idx,
                                             input int unsigned width);
        logic [PRICE_VEC_MAX-1:0] mask;
        mask = (PRICE_VEC_MAX'(1) << width) - PRICE_VEC_MAX'(1);
        return 32'((vec >> (idx * width)) & mask);
    endfunction

endpackage

// File: rtl/vend_change_ejector.sv
// Change-return loop: offers the largest coin that still fits in the remaining credit,
// one chg_req/chg_ack handshake per coin, and tells the top how much credit each ack consumed.
module vend_change_ejector
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CREDIT_W-1:0] credit,
    input  logic                chg_ack,
    output logic                chg_req,
    output logic [1:0]          chg_coin,
    output logic [CREDIT_W-1:0] dec,
    output logic                done
);

    logic                take;
    logic [CREDIT_W-1:0] remaining;

    function automatic logic [1:0] coin_for(input logic [CREDIT_W-1:0] amount);
        return (amount >= CREDIT_W'(UNIT_10)) ? COIN_10 : COIN_5;
    endfunction

    assign take      = chg_req && chg_ack;
    assign dec       = take ? CREDIT_W'(coin_units(chg_coin)) : '0;
    assign remaining = credit - dec;
    assign done      = take && (remaining == '0);

    // NOTE: registers are updated with <= so every flop samples pre-edge values, no ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_req  <= 1'b0;
            chg_coin <= COIN_NONE;
        end else if (start) begin
            chg_req  <= (credit != '0);
            chg_coin <= coin_for(credit);
        end else if (take) begin
            if (remaining == '0) begin
                chg_req  <= 1'b0;
                chg_coin <= COIN_NONE;
            end else begin
                chg_coin <= coin_for(remaining);
            end
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit accumulation, selection checks,
// dispense handshake and change return. All outputs are registered.
module vend_controller
    import vend_pkg::*;
#(
    parameter  int N_ITEMS    = 4,
    parameter  int CREDIT_W   = 5,
    parameter  int MAX_CREDIT = 20,
    localparam int IDX_W      = $clog2(N_ITEMS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        coin_valid,
    input  logic [1:0]                  coin,
    output logic                        coin_reject,
    input  logic                        sel_valid,
    input  logic [IDX_W-1:0]            sel_idx,
    input  logic                        cancel,
    input  logic [N_ITEMS*CREDIT_W-1:0] price,
    input  logic [N_ITEMS-1:0]          in_stock,
    output logic                        sel_err,
    output logic                        disp_req,
    output logic [IDX_W-1:0]            disp_idx,
    input  logic                        disp_done,
    output logic                        chg_req,
    output logic [1:0]                  chg_coin,
    input  logic                        chg_ack,
    output logic [CREDIT_W-1:0]         credit,
    output logic                        busy
);

    state_t state, state_next;

    logic [CREDIT_W-1:0] credit_next;
    logic                coin_reject_next;
    logic                sel_err_next;
    logic [IDX_W-1:0]    disp_idx_next;

    logic [CREDIT_W:0]   credit_sum;
    logic [CREDIT_W-1:0] price_sel;
    logic [1:0]          units;
    logic                coin_ok;
    logic                sel_ok;

    logic                chg_start;
    logic [CREDIT_W-1:0] chg_dec;
    logic                chg_done;

    assign units      = coin_units(coin);
    assign credit_sum = {1'b0, credit} + (CREDIT_W+1)'(units);
    assign coin_ok    = coin_valid && (units != 2'd0)
                        && (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));

    assign price_sel = CREDIT_W'(price_at(PRICE_VEC_MAX'(price), 32'(sel_idx), CREDIT_W));
    assign sel_ok    = (32'(sel_idx) < N_ITEMS) && in_stock[sel_idx] && (credit >= price_sel);

    // The ejector loads its first coin on the same edge the FSM enters CHANGE.
    assign chg_start = (state != S_CHANGE) && (state_next == S_CHANGE);

    vend_change_ejector #(
        .CREDIT_W (CREDIT_W)
    ) u_ejector (
        .clk      (clk),
        .rst      (rst),
        .start    (chg_start),
        .credit   (credit),
        .chg_ack  (chg_ack),
        .chg_req  (chg_req),
        .chg_coin (chg_coin),
        .dec      (chg_dec),
        .done     (chg_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            credit      <= '0;
            coin_reject <= 1'b0;
            sel_err     <= 1'b0;
            disp_req    <= 1'b0;
            disp_idx    <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            credit      <= credit_next;
            coin_reject <= coin_reject_next;
            sel_err     <= sel_err_next;
            disp_req    <= (state_next == S_DISPENSE);
            disp_idx    <= disp_idx_next;
            busy        <= (state_next == S_DISPENSE) || (state_next == S_CHANGE);
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (coin_ok) state_next = S_CREDIT;
            end
            S_CREDIT: begin
                if (cancel)
                    state_next = (credit != '0) ? S_CHANGE : S_IDLE;
                else if (sel_valid && sel_ok)
                    state_next = S_DISPENSE;
            end
            S_DISPENSE: begin
                if (disp_done)
                    state_next = (credit != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                if (chg_done) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Any strobed coin is refused unless a branch below explicitly accepts it.
    always_comb begin
        credit_next      = credit;
        coin_reject_next = coin_valid;
        sel_err_next     = 1'b0;
        disp_idx_next    = disp_idx;
        case (state)
            S_IDLE: begin
                sel_err_next = sel_valid;
                if (coin_ok) begin
                    credit_next      = credit_sum[CREDIT_W-1:0];
                    coin_reject_next = 1'b0;
                end
            end
            S_CREDIT: begin
                if (cancel) begin
                    credit_next = credit;
                end else if (sel_valid) begin
                    if (sel_ok) begin
                        credit_next   = credit - price_sel;
                        disp_idx_next = sel_idx;
                    end else begin
                        sel_err_next = 1'b1;
                    end
                end else if (coin_ok) begin
                    credit_next      = credit_sum[CREDIT_W-1:0];
                    coin_reject_next = 1'b0;
                end
            end
            S_CHANGE: begin
                credit_next = credit - chg_dec;
            end
            default: begin
                credit_next = credit;
            end
        endcase
    end

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: stimulus pushes expected output events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_vend_controller;

    localparam int N_ITEMS    = 4;
    localparam int CREDIT_W   = 5;
    localparam int MAX_CREDIT = 20;

    localparam int EV_REJ  = 1;
    localparam int EV_SERR = 2;
    localparam int EV_DISP = 3;
    localparam int EV_CHG  = 4;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        coin_valid = 1'b0;
    logic [1:0]                  coin = 2'b00;
    logic                        coin_reject;
    logic                        sel_valid = 1'b0;
    logic [1:0]                  sel_idx = 2'd0;
    logic                        cancel = 1'b0;
    logic [N_ITEMS*CREDIT_W-1:0] price;
    logic [N_ITEMS-1:0]          in_stock;
    logic                        sel_err;
    logic                        disp_req;
    logic [1:0]                  disp_idx;
    logic                        disp_done = 1'b0;
    logic                        chg_req;
    logic [1:0]                  chg_coin;
    logic                        chg_ack = 1'b0;
    logic [CREDIT_W-1:0]         credit;
    logic                        busy;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    logic prev_disp = 1'b0;
    logic prev_chg  = 1'b0;
    logic prev_ack  = 1'b0;

    // item3..item0 prices 4, 2, 3, 2 units; item3 out of stock
    assign price    = {5'd4, 5'd2, 5'd3, 5'd2};
    assign in_stock = 4'b0111;

    vend_controller #(
        .N_ITEMS    (N_ITEMS),
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin        (coin),
        .coin_reject (coin_reject),
        .sel_valid   (sel_valid),
        .sel_idx     (sel_idx),
        .cancel      (cancel),
        .price       (price),
        .in_stock    (in_stock),
        .sel_err     (sel_err),
        .disp_req    (disp_req),
        .disp_idx    (disp_idx),
        .disp_done   (disp_done),
        .chg_req     (chg_req),
        .chg_coin    (chg_coin),
        .chg_ack     (chg_ack),
        .credit      (credit),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ev(input int kind, input int data, input int cr);
        return (kind << 16) | (data << 8) | cr;
    endfunction

    task automatic push(input int kind, input int data, input int cr);
        exp_q.push_back(ev(kind, data, cr));
    endtask

    task automatic observe(input int code);
        int expv;
        if (exp_q.size() == 0) begin
            check("unexpected_event", code, 32'hFFFF_FFFF);
        end else begin
            expv = exp_q.pop_front();
            check("scoreboard_event", code, expv);
        end
    endtask

    // Monitor: one event per pulse, per disp_req rise, and per new change coin offered.
    initial begin
        forever begin
            @(negedge clk);
            if (coin_reject) observe(ev(EV_REJ, 0, int'(credit)));
            if (sel_err)     observe(ev(EV_SERR, 0, int'(credit)));
            if (disp_req && !prev_disp) observe(ev(EV_DISP, int'(disp_idx), int'(credit)));
            if (chg_req && (!prev_chg || prev_ack)) observe(ev(EV_CHG, int'(chg_coin), int'(credit)));
            prev_disp = disp_req;
            prev_chg  = chg_req;
            prev_ack  = chg_ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin_in(input logic [1:0] c);
        coin_valid = 1'b1;
        coin       = c;
        tick();
        coin_valid = 1'b0;
        coin       = 2'b00;
    endtask

    task automatic select(input logic [1:0] idx);
        sel_valid = 1'b1;
        sel_idx   = idx;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic pulse_done();
        disp_done = 1'b1;
        tick();
        disp_done = 1'b0;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic ack_change();
        for (int i = 0; i < 50 && !chg_req; i++) tick();
        check("chg_req_before_ack", chg_req, 1);
        chg_ack = 1'b1;
        tick();
        chg_ack = 1'b0;
    endtask

    function automatic logic [13:0] all_outputs();
        return {coin_reject, sel_err, disp_req, disp_idx, chg_req, chg_coin, credit, busy};
    endfunction

    initial begin
        int r;

        // Reset state
        tick();
        tick();
        check("reset_outputs", all_outputs(), 14'd0);
        rst = 1'b0;
        tick();

        // Invalid coin in IDLE is refused; selection in IDLE errors
        push(EV_REJ, 0, 0);
        coin_in(2'b11);
        push(EV_SERR, 0, 0);
        select(2'd0);
        check("idle_credit", credit, 0);

        // 10rs + 5rs, item1 (price 3) -> dispense idx 1, credit 0, no change
        coin_in(2'b10);
        coin_in(2'b01);
        check("credit_3", credit, 3);
        push(EV_DISP, 1, 0);
        select(2'd1);
        check("disp_req_up", {disp_req, busy}, 2'b11);
        push(EV_REJ, 0, 0);
        coin_in(2'b10);
        check("disp_idx_stable", {disp_req, disp_idx}, {1'b1, 2'd1});
        pulse_done();
        check("after_done_no_change", {disp_req, chg_req, busy}, 3'b000);
        tick();
        tick();
        check("idle_no_change", chg_req, 0);

        // Credit 5, item0 (price 2) -> change 10rs then 5rs
        coin_in(2'b10);
        coin_in(2'b10);
        coin_in(2'b01);
        check("credit_5", credit, 5);
        push(EV_DISP, 0, 3);
        select(2'd0);
        push(EV_CHG, 2, 3);
        pulse_done();
        check("chg_after_done", {disp_req, chg_req, busy}, 3'b011);
        push(EV_CHG, 1, 1);
        ack_change();
        check("chg_still_req", {chg_req, chg_coin, credit}, {1'b1, 2'b01, 5'd1});
        ack_change();
        check("change_complete", {chg_req, busy, credit}, {2'b00, 5'd0});

        // Credit ceiling: 19 then 10rs refused, 5rs reaches 20
        for (int i = 0; i < 9; i++) coin_in(2'b10);
        coin_in(2'b01);
        check("credit_19", credit, 19);
        push(EV_REJ, 0, 19);
        coin_in(2'b10);
        check("credit_held_19", credit, 19);
        coin_in(2'b01);
        check("credit_20", credit, 20);

        // Cancel refunds 20 units as ten 10rs coins
        push(EV_CHG, 2, 20);
        pulse_cancel();
        r = 20;
        while (r > 0) begin
            r -= 2;
            if (r > 0) push(EV_CHG, (r >= 2) ? 2 : 1, r);
            ack_change();
        end
        check("refund_complete", {chg_req, busy, credit}, {2'b00, 5'd0});

        // Refused selections keep state and credit
        coin_in(2'b01);
        push(EV_SERR, 0, 1);
        select(2'd3);
        push(EV_SERR, 0, 1);
        select(2'd0);
        check("sel_err_credit", {busy, disp_req, credit}, {2'b00, 5'd1});
        coin_in(2'b10);
        coin_in(2'b01);
        check("credit_4", credit, 4);

        // cancel + sel + coin together at credit 4: cancel wins, coin refused
        push(EV_REJ, 0, 4);
        push(EV_CHG, 2, 4);
        cancel     = 1'b1;
        sel_valid  = 1'b1;
        sel_idx    = 2'd0;
        coin_valid = 1'b1;
        coin       = 2'b01;
        tick();
        cancel     = 1'b0;
        sel_valid  = 1'b0;
        coin_valid = 1'b0;
        coin       = 2'b00;
        check("cancel_priority", {disp_req, chg_req, credit}, {2'b01, 5'd4});
        push(EV_CHG, 2, 2);
        ack_change();
        ack_change();
        check("cancel_refund_done", {chg_req, busy, credit}, {2'b00, 5'd0});

        // Reset during dispense aborts; late disp_done ignored
        coin_in(2'b10);
        push(EV_DISP, 0, 0);
        select(2'd0);
        check("disp_before_rst", disp_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_abort_outputs", all_outputs(), 14'd0);
        pulse_done();
        tick();
        check("late_done_ignored", all_outputs(), 14'd0);

        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction sequencer for the multi-item vending machine. It accumulates coin credit in 5rs units, checks selections against price and stock, drives the dispense-motor handshake, and returns change as a sequence of 10rs/5rs coin-ejector handshakes. It sits between the coin acceptor/keypad front end and the dispenser and change-ejector actuators.

## Interface
- N_ITEMS, 4, number of selectable items (≥2)
- CREDIT_W, 5, credit register width in 5rs units
- MAX_CREDIT, 20, credit ceiling in units (20 = 100rs); must be < 2^CREDIT_W

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- coin_valid  in  1  one-cycle coin strobe
- coin  in  2  01 = 5rs, 10 = 10rs, 00/11 = invalid
- coin_reject  out  1  one-cycle pulse: strobed coin refused (return chute)
- sel_valid  in  1  one-cycle selection strobe
- sel_idx  in  $clog2(N_ITEMS)  selected item
- cancel  in  1  one-cycle refund request
- price  in  N_ITEMS*CREDIT_W  per-item price in units, item i at [i*CREDIT_W +: CREDIT_W]; static
- in_stock  in  N_ITEMS  per-item availability
- sel_err  out  1  one-cycle pulse: selection refused
- disp_req, disp_idx  out  1, $clog2(N_ITEMS)  dispense request, held until done
- disp_done  in  1  dispenser completion
- chg_req  out  1  change-coin request, held until ack
- chg_coin  out  2  01 = 5rs, 10 = 10rs, valid while chg_req
- chg_ack  in  1  ejector accepted the coin
- credit  out  CREDIT_W  current credit in units
- busy  out  1  high in DISPENSE and CHANGE

## Operation
- States: IDLE, CREDIT, DISPENSE, CHANGE.
- Reset: state IDLE; credit, coin_reject, sel_err, disp_req, disp_idx, chg_req, chg_coin, and busy all 0.
- Coin value: 01 → 1 unit, 10 → 2 units.
- Coins are accepted only in IDLE and CREDIT. A coin is rejected if invalid, if credit + value > MAX_CREDIT, or if the machine is in DISPENSE or CHANGE.
- IDLE: an accepted coin adds to credit and moves to CREDIT. sel_valid produces sel_err. cancel is ignored.
- CREDIT, per-cycle priority is cancel > sel_valid > coin_valid. A lower-priority event arriving in the same cycle is dropped; a dropped coin pulses coin_reject.
  - cancel → CHANGE.
  - sel_valid with sel_idx < N_ITEMS, in_stock[sel_idx] = 1 and credit ≥ price[sel_idx]: credit -= price, latch disp_idx, go to DISPENSE.
  - Any other selection: sel_err, stay in CREDIT.
  - Accepted coin: credit += value.
- DISPENSE: disp_req = 1 with a stable disp_idx. On disp_done: credit > 0 → CHANGE, otherwise → IDLE.
- CHANGE: chg_req = 1 with chg_coin = 10 if credit ≥ 2, else 01. On chg_ack: credit -= coin value. When credit reaches 0 → IDLE.
- sel_valid and cancel are ignored while busy.
- Arithmetic is unsigned CREDIT_W. Overflow cannot occur because of the MAX_CREDIT check; underflow cannot occur because of the price and change checks.

## Timing
- All outputs are registered and update on the clock edge after the causing input.
- coin_reject and sel_err are single-cycle pulses, 1 cycle after the strobe.
- Accepted selection: disp_req rises 1 cycle after sel_valid. credit shows the reduced value in the same cycle.
- disp_done sampled high in cycle t: disp_req low at t+1; chg_req high at t+1 if change is owed.
- chg_ack at t: credit updates at t+1. chg_req drops at t+1 only if credit becomes 0; otherwise chg_req stays high and chg_coin shows the next coin.
- disp_done or chg_ack outside the matching state is ignored.
- rst mid-transaction aborts immediately to IDLE with credit cleared. No refund is issued; accepted as a power-on/service behaviour.

## Structure
- Shared package vend_pkg: state enum, coin encodings (COIN_5, COIN_10), unit values, and a price_at(index) helper.
- One natural sub-module, vend_change_ejector: owns the CHANGE-state coin-selection loop and the chg_req/chg_ack handshake. Interface: start, credit in, credit decrement out, done.

## Test plan
- 10rs + 5rs in, select item 1 with price 3, stock 1 → disp_req with idx 1 one cycle later, credit 0; after disp_done → IDLE, no chg_req.
- Credit 5 units, select price 2 → dispense, then change: chg_coin 10 (ack), then 01 (ack) → credit 0, IDLE.
- Credit 19 units, insert 10rs → coin_reject pulse, credit stays 19. Then 5rs → credit 20.
- Out-of-stock selection, and selection with credit 1 vs price 2 → sel_err pulse each time, state CREDIT, credit unchanged.
- cancel, sel_valid and coin_valid in the same cycle at credit 4 → CHANGE, coin_reject pulse; refund 10rs then 10rs.
- rst asserted while disp_req is high → next cycle IDLE, all outputs 0; a subsequent disp_done is ignored.
